// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the radix-2 restoring divider.
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = 5;

  localparam logic [DIV_W-1:0] DIV_DVZ_QUO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Magnitude of a two's-complement value, applied only for signed operations.
  function automatic logic [DIV_W-1:0] abs_if(input logic [DIV_W-1:0] v, input logic en);
    return (en && v[DIV_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_radix2_if.sv
// Divide request/complete handshake between the EXE stage (master) and the divider (slave).
interface div_radix2_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
);

  logic             div;
  logic             div_signed;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             div_ack;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             complete;

  modport master (
    output div, div_signed, x, y, div_ack,
    input  s, r, complete
  );

  modport slave (
    input  div, div_signed, x, y, div_ack,
    output s, r, complete
  );

endinterface

// File: rtl/div_radix2_step.sv
// One combinational restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_radix2_step
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] rem_i,
  input  logic [DIV_W-1:0] quo_i,
  input  logic [DIV_W-1:0] dsr_i,
  output logic [DIV_W-1:0] rem_o,
  output logic [DIV_W-1:0] quo_o
);

  logic [DIV_W:0] rem_sh;
  logic [DIV_W:0] trial;
  logic           q_bit;

  always_comb begin
    rem_sh = {rem_i, quo_i[DIV_W-1]};
    trial  = rem_sh - {1'b0, dsr_i};
    // A set top bit means the shifted remainder already exceeds any 32-bit divisor.
    q_bit  = rem_sh[DIV_W] | ~trial[DIV_W];
    rem_o  = q_bit ? trial[DIV_W-1:0] : rem_sh[DIV_W-1:0];
    quo_o  = {quo_i[DIV_W-2:0], q_bit};
  end

endmodule

// File: rtl/div_radix2.sv
// Iterative 32-bit signed/unsigned radix-2 restoring divider returning quotient and remainder.
//
// state | meaning
// IDLE  | waiting for div; latches operand magnitudes and result signs on request
// RUN   | 32 shift/subtract iterations; div low aborts back to IDLE
// DONE  | complete=1 with registered s/r; leaves on div_ack or div withdrawn
module div_radix2
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
)(
  input  logic          div_clk,
  input  logic          resetn,
  div_radix2_if.slave   bus
);

  localparam logic [1:0] IDLE = DIV_IDLE;
  localparam logic [1:0] RUN  = DIV_RUN;
  localparam logic [1:0] DONE = DIV_DONE;

  logic [1:0]           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dsr_q, dsr_d;
  logic                 neg_q_q, neg_q_d;
  logic                 neg_r_q, neg_r_d;
  logic                 dvz_q, dvz_d;
  logic [WIDTH-1:0]     s_q, s_d;
  logic [WIDTH-1:0]     r_q, r_d;

  logic [WIDTH-1:0]     step_rem;
  logic [WIDTH-1:0]     step_quo;

  div_radix2_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    dvz_d   = dvz_q;
    s_d     = s_q;
    r_d     = r_q;

    case (state_q)
      IDLE: begin
        if (bus.div) begin
          state_d = RUN;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = abs_if(bus.x, bus.div_signed);
          dsr_d   = abs_if(bus.y, bus.div_signed);
          neg_q_d = bus.div_signed & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
          neg_r_d = bus.div_signed & bus.x[WIDTH-1];
          dvz_d   = (bus.y == '0);
        end
      end
      RUN: begin
        if (!bus.div) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DIV_CNT_W'(DIV_ITER - 1)) begin
            state_d = DONE;
            s_d     = dvz_q ? DIV_DVZ_QUO : (neg_q_q ? -step_quo : step_quo);
            // On divide by zero the remainder ends as |x|; restoring x's sign returns x itself.
            r_d     = neg_r_q ? -step_rem : step_rem;
          end
        end
      end
      DONE: begin
        if (bus.div_ack || !bus.div) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dvz_q   <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      dvz_q   <= dvz_d;
      s_q     <= s_d;
      r_q     <= r_d;
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.complete = (state_q == DONE);

endmodule

// File: tb/tb_div_radix2.sv
// Randomized self-checking bench for div_radix2 against an arithmetic reference model.
module tb_div_radix2;

  logic div_clk;
  logic resetn;

  div_radix2_if bus ();

  div_radix2 dut (
    .div_clk (div_clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  initial div_clk = 1'b0;
  always #5 div_clk = ~div_clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        chk_en = 1'b0;
  logic        chk_sr = 1'b0;
  logic        exp_complete = 1'b0;
  logic [31:0] exp_s = '0;
  logic [31:0] exp_r = '0;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
    logic [31:0] q;
    logic [31:0] rm;
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      rm = a;
    end else if (!sg) begin
      q  = a / b;
      rm = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q  = 32'h8000_0000;
      rm = 32'd0;
    end else begin
      q  = sa / sb;
      rm = sa % sb;
    end
    return {q, rm};
  endfunction

  // Compare process: model pins once, then complete and s/r every cycle.
  initial begin
    logic [63:0] m;
    @(negedge div_clk);
    m = model(32'd100, 32'd7, 1'b0);
    n_cmp++; if (m !== {32'd14, 32'd2}) begin n_err++; $display("FAIL pin_100_7: got %h required %h", m, {32'd14, 32'd2}); end
    m = model(32'hFFFF_FFF9, 32'd2, 1'b1);
    n_cmp++; if (m !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL pin_m7_2s: got %h required %h", m, {32'hFFFF_FFFD, 32'hFFFF_FFFF}); end
    m = model(32'hFFFF_FFF9, 32'd2, 1'b0);
    n_cmp++; if (m !== {32'h7FFF_FFFC, 32'd1}) begin n_err++; $display("FAIL pin_m7_2u: got %h required %h", m, {32'h7FFF_FFFC, 32'd1}); end
    m = model(32'h1234_5678, 32'd0, 1'b1);
    n_cmp++; if (m !== {32'hFFFF_FFFF, 32'h1234_5678}) begin n_err++; $display("FAIL pin_dvz: got %h required %h", m, {32'hFFFF_FFFF, 32'h1234_5678}); end
    m = model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    n_cmp++; if (m !== {32'h8000_0000, 32'd0}) begin n_err++; $display("FAIL pin_ovf: got %h required %h", m, {32'h8000_0000, 32'd0}); end
    m = model(32'd9, 32'd4, 1'b0);
    n_cmp++; if (m !== {32'd2, 32'd1}) begin n_err++; $display("FAIL pin_9_4: got %h required %h", m, {32'd2, 32'd1}); end
    forever begin
      @(negedge div_clk);
      if (chk_en) begin
        n_cmp++;
        if (bus.complete !== exp_complete) begin
          n_err++;
          $display("FAIL complete @%0t: got %b required %b", $time, bus.complete, exp_complete);
        end
        if (chk_sr) begin
          n_cmp++;
          if (bus.s !== exp_s || bus.r !== exp_r) begin
            n_err++;
            $display("FAIL result @%0t: got s=%h r=%h required s=%h r=%h", $time, bus.s, bus.r, exp_s, exp_r);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called in an IDLE cycle just after a rising edge; returns in the first DONE cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sg);
    logic [63:0] e;
    e = model(a, b, sg);
    bus.div        = 1'b1;
    bus.x          = a;
    bus.y          = b;
    bus.div_signed = sg;
    bus.div_ack    = 1'b0;
    exp_complete   = 1'b0;
    chk_sr         = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(posedge div_clk); #1;
      bus.x          = $urandom;
      bus.y          = $urandom;
      bus.div_signed = 1'($urandom_range(0, 1));
      bus.div_ack    = (k < 33) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == 33) begin
        exp_complete = 1'b1;
        exp_s        = e[63:32];
        exp_r        = e[31:0];
        chk_sr       = 1'b1;
      end
    end
  endtask

  // Holds DONE for wait_n cycles, then acks (or withdraws div); returns in the following IDLE cycle.
  task automatic end_op(input int wait_n, input logic use_ack, input logic keep_div);
    repeat (wait_n) begin
      @(posedge div_clk); #1;
      bus.x = $urandom;
      bus.y = $urandom;
    end
    if (use_ack) bus.div_ack = 1'b1;
    else         bus.div     = 1'b0;
    @(posedge div_clk); #1;
    bus.div_ack  = 1'b0;
    bus.div      = keep_div;
    exp_complete = 1'b0;
    chk_sr       = 1'b0;
  endtask

  // Starts 100/7, then at RUN iteration 10 either resets or drops div.
  task automatic abort_op(input logic use_reset);
    bus.div        = 1'b1;
    bus.x          = 32'd100;
    bus.y          = 32'd7;
    bus.div_signed = 1'b0;
    repeat (11) begin
      @(posedge div_clk); #1;
      bus.x = $urandom;
      bus.y = $urandom;
    end
    if (use_reset) resetn  = 1'b0;
    else           bus.div = 1'b0;
    @(posedge div_clk); #1;
    bus.div = 1'b0;
    if (use_reset) begin
      exp_s  = 32'd0;
      exp_r  = 32'd0;
      chk_sr = 1'b1;
      resetn = 1'b1;
    end
    @(posedge div_clk); #1;
    chk_sr = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int sel;
    resetn         = 1'b0;
    bus.div        = 1'b0;
    bus.div_signed = 1'b0;
    bus.x          = 32'h0;
    bus.y          = 32'h0;
    bus.div_ack    = 1'b0;
    exp_complete   = 1'b0;
    exp_s          = 32'd0;
    exp_r          = 32'd0;
    chk_sr         = 1'b1;
    @(posedge div_clk); #1;
    chk_en = 1'b1;
    @(posedge div_clk); #1;
    resetn = 1'b1;
    @(posedge div_clk); #1;

    do_op(32'd100, 32'd7, 1'b0);                  end_op(0, 1'b1, 1'b0);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1);            end_op(1, 1'b1, 1'b0);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b0);            end_op(0, 1'b0, 1'b0);
    do_op(32'h1234_5678, 32'd0, 1'b1);            end_op(2, 1'b1, 1'b0);
    do_op(32'h1234_5678, 32'd0, 1'b0);            end_op(0, 1'b1, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);    end_op(0, 1'b1, 1'b0);
    do_op(32'hDEAD_BEEF, 32'h0000_1234, 1'b1);    end_op(5, 1'b1, 1'b1);
    do_op(32'd9, 32'd4, 1'b0);                    end_op(0, 1'b1, 1'b0);
    abort_op(1'b1);
    do_op(32'd100, 32'd7, 1'b0);                  end_op(0, 1'b1, 1'b0);
    abort_op(1'b0);
    do_op(32'd100, 32'd7, 1'b0);                  end_op(0, 1'b1, 1'b0);

    for (int i = 0; i < 25; i++) begin
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        4: begin a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 50)); end
        default: ;
      endcase
      do_op(a, b, 1'($urandom_range(0, 1)));
      end_op($urandom_range(0, 3), 1'($urandom_range(0, 3) != 0), 1'b0);
    end

    @(posedge div_clk); #1;
    chk_en = 1'b0;
    @(negedge div_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_radix2.md
# div_radix2

Iterative 32-bit radix-2 restoring divider. It serves the EXE stage's divide request/complete handshake: EXE raises `div` with operands, stalls its ready-go until `complete`, then retires the result. It supports signed and unsigned division (div.w/mod.w/div.wu/mod.wu) and returns both quotient and remainder. EXE selects between the two.

## Interface
- Parameters:
- `WIDTH`, 32, operand/result width; only 32 is supported.
- Ports:
- `div_clk` in 1: clock.
- `resetn` in 1: synchronous, active-low reset.
- `div` in 1: divide request, held by EXE while a divide instruction is valid in EXE.
- `div_signed` in 1: 1 = signed, 0 = unsigned; sampled at start.
- `x` in 32: dividend; sampled at start.
- `y` in 32: divisor; sampled at start.
- `div_ack` in 1: EXE consumed the result (exe_to_mem_valid & mem_allowin).
- `s` out 32: quotient.
- `r` out 32: remainder.
- `complete` out 1: `s`/`r` valid; held until acknowledged.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If `div`=1, latch `div_signed`, |x|, |y|, sign of quotient (x[31]^y[31] when signed), sign of remainder (x[31] when signed).
  - Clear the partial remainder and counter, then go to RUN.
  - Absolute value is computed only when `div_signed`=1; otherwise the operands are taken raw.
- RUN, 32 iterations, counter 0..31:
  - Shift {rem, quo} left by 1, bringing in the next dividend MSB.
  - Form a 33-bit trial `rem - |y|`.
  - If the trial is non-negative, rem ← trial and quotient bit = 1; else quotient bit = 0.
  - After counter = 31, go to DONE.
- DONE:
  - Drive sign-corrected results: s = neg_q ? −q : q; r = neg_r ? −rem : rem.
  - `complete`=1.
  - Leave to IDLE when `div_ack`=1 or `div`=0 (request withdrawn).
- Operand inputs changing during RUN/DONE have no effect.
- Divide by zero:
  - No trap and no hang; same latency.
  - s = 32'hFFFF_FFFF and r = x (original value), regardless of `div_signed`.
  - Sign correction is bypassed.
- Signed overflow: 0x8000_0000 / −1 gives s = 0x8000_0000, r = 0 (natural modulo-2^32 wrap).
- Results are all 32 bits: quotient rounds toward zero; remainder takes the dividend's sign.

## Timing
- Reset: state IDLE, `complete`=0, `s`=0, `r`=0, counter=0.
- Reset wins over all other inputs, including mid-RUN and in DONE; no partial result is ever visible.
- Latency: `div` sampled in IDLE at cycle 0 → RUN cycles 1–32 → `complete`=1 from cycle 33.
- `s`/`r` are registered and stable for every cycle `complete`=1.
- `complete` is 0 in IDLE and RUN.
- An ack and the next request cannot overlap:
  - After the DONE→IDLE exit there is one IDLE cycle.
  - A still-high `div` in that cycle (back-to-back divide) starts a new operation.
  - Back-to-back throughput is 34 cycles per divide.
- `div` dropping during RUN (pipeline flush) aborts to IDLE on the next edge; `complete` is not raised.
- `div_ack` outside DONE is ignored.

## Structure
- Shared package `div_pkg` holds:
  - state enum (IDLE/RUN/DONE);
  - `DIV_W`=32;
  - `DIV_ITER`=32;
  - counter width 5;
  - divide-by-zero quotient constant 32'hFFFF_FFFF.
- One sub-module, `div_radix2_step`: combinational single iteration. Takes the 33-bit trial subtract and quotient-bit decision, inputs {rem, quo, divisor}, outputs {rem', quo'}.
- Top level holds the FSM, counter, operand/sign registers and sign correction.

## Test plan
- Unsigned 100/7 → complete at cycle 33; s=14, r=2.
- Signed: x=0xFFFF_FFF9 (−7), y=2 → s=0xFFFF_FFFD (−3), r=0xFFFF_FFFF (−1).
- The same operands unsigned → s=0x7FFF_FFFC, r=1.
- Divide by zero: x=0x1234_5678, y=0, signed and unsigned → s=0xFFFF_FFFF, r=0x1234_5678 at cycle 33.
- Signed 0x8000_0000 / 0xFFFF_FFFF → s=0x8000_0000, r=0.
- Hold `div_ack`=0 for 5 cycles in DONE → `complete` and results are stable throughout. Then ack with `div` still high and new operands 9/4 → second result s=2, r=1, 34 cycles after the ack.
- `resetn`=0 at RUN iteration 10 → next cycle IDLE, `complete`=0, s=r=0.
- `div` dropped at iteration 10 → IDLE with no `complete`; a subsequent 100/7 is still correct.
